// File: rtl/food_placer_pkg.sv
// rtl/food_placer_pkg.sv - shared constants and types for the food placer
// Purpose: cell codes, cell width, LFSR seed/taps and FSM state type used by
//          food_placer, food_lfsr and food_placer_if.
package food_placer_pkg;

  localparam int BITS_PER_BLOCK = 2;

  localparam logic [1:0] BLOCK_EMPTY = 2'd0;
  localparam logic [1:0] BLOCK_WALL  = 2'd1;
  localparam logic [1:0] BLOCK_SNAKE = 2'd2;
  localparam logic [1:0] BLOCK_FOOD  = 2'd3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as a mask over state bits [15],[13],[12],[10].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_CHECK,
    ST_SCAN,
    ST_DONE
  } fp_state_e;

endpackage

// File: rtl/food_placer_if.sv
// rtl/food_placer_if.sv - request/result bus between the game logic and the food placer
// Purpose: bundles the grid, request, entropy and placement result signals.
// Ports (modport slave = placer side):
//   Blocks  in  flattened grid [0:N-1], cell (v,h) at BITS_PER_BLOCK*(v*GRID_W+h), lowest index = LSB
//   Request in  start a placement
//   Entropy in  button levels for the LFSR
//   FoodV/FoodH out placed row/column; Busy out not idle; Valid/Fail out one-cycle result pulses
interface food_placer_if #(
  parameter int GRID_W         = 16,
  parameter int GRID_H         = 16,
  parameter int BITS_PER_BLOCK = food_placer_pkg::BITS_PER_BLOCK
);

  logic [0:BITS_PER_BLOCK*GRID_H*GRID_W-1] Blocks;
  logic                                   Request;
  logic [3:0]                             Entropy;
  logic [$clog2(GRID_H)-1:0]              FoodV;
  logic [$clog2(GRID_W)-1:0]              FoodH;
  logic                                   Busy;
  logic                                   Valid;
  logic                                   Fail;

  modport master (
    output Blocks, Request, Entropy,
    input  FoodV, FoodH, Busy, Valid, Fail
  );

  modport slave (
    input  Blocks, Request, Entropy,
    output FoodV, FoodH, Busy, Valid, Fail
  );

endinterface

// File: rtl/food_lfsr.sv
// rtl/food_lfsr.sv - free-running 16-bit Fibonacci LFSR for food placement
// Purpose: advances every cycle from LFSR_SEED. Optional macro FOOD_ENTROPY_EN
//          mixes the parity of the entropy inputs into the feedback.
// Ports: clk, rst (async active-high), entropy[3:0] in, state[15:0] out.
import food_placer_pkg::*;

module food_lfsr (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  entropy,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;
  logic        fb;

`ifdef FOOD_ENTROPY_EN
  always_comb begin
    fb      = (^(state_q & LFSR_TAPS)) ^ (^entropy);
    state_d = {state_q[14:0], fb};
    // Entropy can steer the register into the all-zero lock-up state.
    if (state_d == 16'h0000) begin
      state_d = LFSR_SEED;
    end
  end
`else
  logic unused_entropy;
  assign unused_entropy = ^entropy;

  always_comb begin
    fb      = ^(state_q & LFSR_TAPS);
    state_d = {state_q[14:0], fb};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/food_placer.sv
// rtl/food_placer.sv - picks an empty interior grid cell for the next food item
// Purpose: random draws from an LFSR, falling back to a linear scan after
//          MAX_TRIES occupied hits; reports Fail when no interior cell is empty.
// Ports: MasterClock, Reset (async active-high), bus (food_placer_if.slave).
// Optional macro: FOOD_ENTROPY_EN (entropy mixing inside food_lfsr).
import food_placer_pkg::*;

module food_placer #(
  parameter int GRID_W         = 16,
  parameter int GRID_H         = 16,
  parameter int BITS_PER_BLOCK = food_placer_pkg::BITS_PER_BLOCK,
  parameter int MAX_TRIES      = 8
) (
  input  logic         MasterClock,
  input  logic         Reset,
  food_placer_if.slave bus
);

  localparam int VW    = $clog2(GRID_H);
  localparam int HW    = $clog2(GRID_W);
  localparam int NBITS = BITS_PER_BLOCK * GRID_H * GRID_W;
  localparam int IW    = $clog2(NBITS);
  localparam int CELLS = (GRID_H - 2) * (GRID_W - 2);
  localparam int SW    = $clog2(CELLS + 1);

  localparam logic [VW-1:0] V_LO      = VW'(1);
  localparam logic [VW-1:0] V_HI      = VW'(GRID_H - 2);
  localparam logic [HW-1:0] H_LO      = HW'(1);
  localparam logic [HW-1:0] H_HI      = HW'(GRID_W - 2);
  localparam logic [SW-1:0] SCAN_LAST = SW'(CELLS - 1);
  localparam logic [7:0]    TRIES_MAX = 8'(MAX_TRIES);

  logic [15:0] lfsr;

  food_lfsr u_lfsr (
    .clk     (MasterClock),
    .rst     (Reset),
    .entropy (bus.Entropy),
    .state   (lfsr)
  );

  fp_state_e         state_q, state_d;
  logic [7:0]        tries_q, tries_d;
  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [VW-1:0]     cand_v_q, cand_v_d, food_v_q, food_v_d;
  logic [HW-1:0]     cand_h_q, cand_h_d, food_h_q, food_h_d;
  logic              valid_q, valid_d, fail_q, fail_d;

  logic [VW-1:0]     draw_v, next_v;
  logic [HW-1:0]     draw_h, next_h;
  logic              draw_legal;
  logic [IW-1:0]     cell_idx;
  logic [BITS_PER_BLOCK-1:0] cand_code;
  logic              cand_empty;

  // Only the low row bits and high column bits of the LFSR feed the draw.
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr;

  assign draw_v     = lfsr[VW-1:0];
  assign draw_h     = lfsr[15 -: HW];
  assign draw_legal = (draw_v >= V_LO) && (draw_v <= V_HI) &&
                      (draw_h >= H_LO) && (draw_h <= H_HI);

  // Code of the cell held in the candidate registers.
  always_comb begin
    cell_idx  = '0;
    cand_code = '0;
    for (int b = 0; b < BITS_PER_BLOCK; b++) begin
      cell_idx     = IW'(BITS_PER_BLOCK * (int'(cand_v_q) * GRID_W + int'(cand_h_q)) + b);
      cand_code[b] = bus.Blocks[cell_idx];
    end
  end

  assign cand_empty = (cand_code == BITS_PER_BLOCK'(BLOCK_EMPTY));

  // Row-major successor of the candidate, wrapping within the interior.
  always_comb begin
    next_v = cand_v_q;
    next_h = cand_h_q + H_LO;
    if (cand_h_q == H_HI) begin
      next_h = H_LO;
      next_v = (cand_v_q == V_HI) ? V_LO : cand_v_q + V_LO;
    end
  end

  always_comb begin
    state_d    = state_q;
    tries_d    = tries_q;
    scan_cnt_d = scan_cnt_q;
    cand_v_d   = cand_v_q;
    cand_h_d   = cand_h_q;
    food_v_d   = food_v_q;
    food_h_d   = food_h_q;
    valid_d    = 1'b0;
    fail_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Request) begin
          state_d = ST_DRAW;
          tries_d = '0;
        end
      end
      ST_DRAW: begin
        // Border draws are discarded without spending a try.
        if (draw_legal) begin
          cand_v_d = draw_v;
          cand_h_d = draw_h;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cand_empty) begin
          food_v_d = cand_v_q;
          food_h_d = cand_h_q;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end else begin
          tries_d = tries_q + 8'd1;
          if (tries_q + 8'd1 == TRIES_MAX) begin
            // The scan starts one cell past the last occupied draw and ends on it.
            cand_v_d   = next_v;
            cand_h_d   = next_h;
            scan_cnt_d = '0;
            state_d    = ST_SCAN;
          end else begin
            state_d = ST_DRAW;
          end
        end
      end
      ST_SCAN: begin
        if (cand_empty) begin
          food_v_d = cand_v_q;
          food_h_d = cand_h_q;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cand_v_d   = next_v;
          cand_h_d   = next_h;
          scan_cnt_d = scan_cnt_q + 1'b1;
          if (scan_cnt_q == SCAN_LAST) begin
            fail_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge MasterClock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      tries_q    <= '0;
      scan_cnt_q <= '0;
      cand_v_q   <= VW'(GRID_H / 2);
      cand_h_q   <= HW'(GRID_W / 2);
      food_v_q   <= VW'(GRID_H / 2);
      food_h_q   <= HW'(GRID_W / 2);
      valid_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      scan_cnt_q <= scan_cnt_d;
      cand_v_q   <= cand_v_d;
      cand_h_q   <= cand_h_d;
      food_v_q   <= food_v_d;
      food_h_q   <= food_h_d;
      valid_q    <= valid_d;
      fail_q     <= fail_d;
    end
  end

  assign bus.FoodV = food_v_q;
  assign bus.FoodH = food_h_q;
  assign bus.Busy  = (state_q != ST_IDLE);
  assign bus.Valid = valid_q;
  assign bus.Fail  = fail_q;

endmodule

// File: doc/food_placer.md
FOOD_PLACER -- requirements
Module: food_placer

Interface
REQ-001 SHALL have parameter GRID_W, default 16, grid columns (>=3).
REQ-002 SHALL have parameter GRID_H, default 16, grid rows (>=3).
REQ-003 SHALL have parameter BITS_PER_BLOCK, default 2, bits per cell code.
REQ-004 SHALL have parameter MAX_TRIES, default 8, random draws before falling back to scan (1..255).
REQ-005 SHALL have port MasterClock  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port Blocks  in  BITS_PER_BLOCK*GRID_H*GRID_W  flattened grid, [0:N-1]; cell (v,h) at base BITS_PER_BLOCK*(v*GRID_W+h), lowest index = cell LSB.
REQ-008 SHALL have port Request  in  1  start a placement, accepted only in IDLE.
REQ-009 SHALL have port Entropy  in  4  button levels mixed into the LFSR (see Configuration).
REQ-010 SHALL have port FoodV  out  clog2(GRID_H)  placed row.
REQ-011 SHALL have port FoodH  out  clog2(GRID_W)  placed column.
REQ-012 SHALL have port Busy  out  1  high in any state other than IDLE.
REQ-013 SHALL have port Valid  out  1  one-cycle pulse, FoodV/FoodH updated this cycle.
REQ-014 SHALL have port Fail  out  1  one-cycle pulse, no empty interior cell exists.

Function
REQ-015 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle, reset to 16'hACE1, never reaching zero.
REQ-016 SHALL treat only interior cells (1..GRID_H-2, 1..GRID_W-2) as legal; border rows/columns are walls.
REQ-017 SHALL implement states IDLE, DRAW, CHECK, SCAN, DONE.
REQ-018 IDLE: Request=1 -> DRAW, try counter cleared; Request=0 -> stay.
REQ-019 DRAW: candidate V = LFSR[clog2(GRID_H)-1:0], H = LFSR[15 -: clog2(GRID_W)]; out-of-interior candidate redraws next cycle without counting a try; legal candidate -> CHECK.
REQ-020 CHECK: cell code == BLOCK_EMPTY -> load FoodV/FoodH, -> DONE with Valid; otherwise try counter +1, back to DRAW, or -> SCAN when counter reaches MAX_TRIES.
REQ-021 SCAN: from last candidate, one cell per cycle, H+1 wrapping GRID_W-2 -> 1 with V+1, V wrapping GRID_H-2 -> 1; first empty cell -> load outputs, DONE with Valid.
REQ-022 SCAN SHALL stop after (GRID_H-2)*(GRID_W-2) cells without a hit -> DONE with Fail, FoodV/FoodH unchanged.
REQ-023 DONE SHALL last one cycle, then IDLE; Valid and Fail never high together.
REQ-024 Minimum Request-to-Valid latency SHALL be 3 cycles (IDLE accept, DRAW, CHECK).
REQ-025 Request while Busy SHALL be ignored, not queued.
REQ-026 Blocks SHALL be sampled combinationally in CHECK/SCAN; driver keeps it stable while Busy.
REQ-027 FoodV/FoodH SHALL hold their value between Valid pulses.

Reset
REQ-028 Reset SHALL force IDLE, LFSR=16'hACE1, try counter 0, scan counter 0.
REQ-029 Reset SHALL force FoodV=GRID_H/2, FoodH=GRID_W/2, Busy=0, Valid=0, Fail=0.
REQ-030 Reset asserted mid-placement SHALL abort it with no Valid or Fail pulse.

Configuration
REQ-031 With FOOD_ENTROPY_EN defined, LFSR feedback SHALL XOR in ^Entropy each cycle (zero state forced to 16'hACE1).
REQ-032 Without FOOD_ENTROPY_EN, Entropy SHALL be ignored and the sequence fully deterministic from reset.

Structure
REQ-033 BLOCK_EMPTY/WALL/SNAKE/FOOD codes, BITS_PER_BLOCK, LFSR seed and taps SHALL live in the shared constants package.
REQ-034 LFSR SHALL be a sub-module named food_lfsr (clock, reset, entropy, 16-bit state out).

Verification
REQ-035 16x16, all interior empty, no FOOD_ENTROPY_EN, Request at cycle 0 after reset -> Valid at cycle 3 or later, FoodV/FoodH in 1..14, cell empty.
REQ-036 All interior SNAKE except (5,9) -> after MAX_TRIES misses SCAN, Valid with FoodV=5, FoodH=9, total latency <= 8+196+redraws+3.
REQ-037 All interior non-empty -> Fail pulse once, Valid never, FoodV/FoodH remain 8/8.
REQ-038 Second Request pulsed during Busy -> exactly one Valid, no second placement.
REQ-039 Reset asserted in SCAN -> next cycle Busy=0, FoodV=8, FoodH=8, no Valid/Fail.
REQ-040 Two runs from reset without FOOD_ENTROPY_EN -> identical FoodV/FoodH sequences; with it and differing Entropy -> sequences differ.
